// File: rtl/bdd_phase_dispatcher.sv
// FIFO-buffered one-hot phase sequencer: each queued item plays out as PHASES strobes.
// Optional build macro PHASE_DISPATCH_BYPASS_EN lets an item skip an empty FIFO.
module bdd_phase_dispatcher #(
  parameter int PHASES     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  hold,
  output logic [PHASES-1:0]     phase,
  output logic [DATA_WIDTH-1:0] phase_data,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = DEPTH[AW:0];
  localparam logic [PHASES-1:0] LP_FIRST = {{(PHASES-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic                  r_ready;
  logic [PHASES-1:0]     r_phase;
  logic [DATA_WIDTH-1:0] r_data;

  logic        w_push;
  logic        w_empty;
  logic        w_load;
  logic        w_byp;
  logic        w_pop;
  logic        w_wr;
  logic [AW:0] w_count_nxt;

  assign w_push  = in_valid & r_ready;
  assign w_empty = (r_count == '0);
  assign done    = r_phase[PHASES-1] & ~hold;
  assign w_load  = ~(|r_phase) | done;
  assign w_pop   = w_load & ~w_empty;

`ifdef PHASE_DISPATCH_BYPASS_EN
  assign w_byp = w_push & w_empty & w_load;
`else
  assign w_byp = 1'b0;
`endif

  assign w_wr        = w_push & ~w_byp;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr}
                     - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != LP_FULL);
    end
  end

  // A finishing item hands straight over to the next one with no idle bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_phase <= LP_FIRST;
      r_data  <= r_mem[r_rptr];
    end else if (w_byp) begin
      r_phase <= LP_FIRST;
      r_data  <= in_data;
    end else if (|r_phase && !hold) begin
      r_phase <= {r_phase[PHASES-2:0], 1'b0};
    end
  end

  assign in_ready   = r_ready;
  assign phase      = r_phase;
  assign phase_data = r_data;
  assign busy       = |r_phase;

endmodule

// File: tb/tb_bdd_phase_dispatcher.sv
// Bench for bdd_phase_dispatcher: directed scenarios plus random traffic
// checked every cycle against a queue-based item model.
module tb_bdd_phase_dispatcher;

  localparam int P  = 4;
  localparam int DW = 16;
  localparam int D  = 4;
`ifdef PHASE_DISPATCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          hold = 1'b0;
  logic [P-1:0]  phase;
  logic [DW-1:0] phase_data;
  logic          busy;
  logic          done;

  bdd_phase_dispatcher #(.PHASES(P), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .hold(hold), .phase(phase), .phase_data(phase_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model: waiting items, the active item and its phase index (-1 = idle)
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  int            m_idx = -1;

  int cyc = 0;
  int n_done = 0;
  int first_done = -1;
  bit saw_full = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit h);
    bit   push, ld, byp, edone;
    logic [P-1:0] ephase;
    @(negedge clk);
    reset = 1'b0;
    in_valid = v;
    in_data = d;
    hold = h;
    #1;
    ephase = (m_idx < 0) ? '0 : P'(1 << m_idx);
    edone = (m_idx == P-1) && !h;
    chk("phase", 32'(phase), 32'(ephase));
    chk("phase_data", 32'(phase_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_idx >= 0));
    chk("done", 32'(done), 32'(edone));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < D));
    if (done) begin
      n_done++;
      if (first_done < 0) first_done = cyc;
    end
    if (!in_ready) saw_full = 1;
    @(posedge clk);
    push = v && (m_q.size() < D);
    ld = (m_idx < 0) || edone;
    byp = 0;
    if (ld) begin
      if (m_q.size() > 0) begin
        m_data = m_q.pop_front();
        m_idx = 0;
      end else if (LAT == 1 && push) begin
        m_data = d;
        m_idx = 0;
        byp = 1;
      end else begin
        m_idx = -1;
      end
    end else if (!h) begin
      m_idx++;
    end
    if (push && !byp) m_q.push_back(d);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    hold = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_data", 32'(phase_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(in_ready), 1);
    m_q.delete();
    m_idx = -1;
    m_data = '0;
  endtask

  initial begin
    int base;
    apply_reset();

    // single item latency
    n_done = 0;
    first_done = -1;
    base = cyc;
    step(1, 16'h00A5, 0);
    idle(8);
    chk("single_done_cnt", 32'(n_done), 1);
    chk("single_done_at", 32'(first_done - base), 32'(LAT + P - 1));

    // three back-to-back items
    n_done = 0;
    for (int i = 0; i < 3; i++) step(1, DW'(16'h1100 + i), 0);
    idle(16);
    chk("b2b_done_cnt", 32'(n_done), 3);

    // valid stuck high, hold stuck during first item
    n_done = 0;
    saw_full = 0;
    step(1, 16'h2000, 0);
    for (int i = 1; i < 12; i++) step(1, DW'(16'h2000 + i), 1);
    idle(1);
    chk("stall_full_seen", 32'(saw_full), 1);
    idle(30);
    chk("stall_done_cnt", 32'(n_done), 5);

    // hold for 3 cycles at phase 0100
    n_done = 0;
    step(1, 16'h3333, 0);
    for (int i = 0; i < 10 && m_idx != 2; i++) idle(1);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    idle(8);
    chk("hold_done_cnt", 32'(n_done), 1);

    // reset with two items queued, active item at phase 0010
    for (int i = 0; i < 3; i++) step(1, DW'(16'h4400 + i), 0);
    for (int i = 0; i < 10 && m_idx != 1; i++) idle(1);
    chk("pre_rst_queued", 32'(m_q.size()), 2);
    apply_reset();
    n_done = 0;
    idle(8);
    chk("post_rst_done", 32'(n_done), 0);
    step(1, 16'h5A5A, 0);
    idle(8);
    chk("post_rst_run", 32'(n_done), 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 55), DW'($urandom),
           ($urandom_range(0, 99) < 25));
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
